// File: rtl/serial_adder.sv
// Bit-serial adder: operands are captured on start, then summed LSB first
// through one full-adder cell and a carry flip-flop, one bit per clock.
// {carryOut, sum} = a + b + carryIn, presented with a one-cycle done pulse.
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carryIn,
  output logic [WIDTH-1:0] sum,
  output logic             carryOut,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t         state;
  state_t         state_nx;
  logic [WIDTH-1:0] ar;
  logic [WIDTH-1:0] br;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] sr_next;
  logic             c;
  logic [CW-1:0]    count;
  logic             s;
  logic             cy;
  logic             last;

  // Full-adder cell on the current LSBs plus the stored carry
  always_comb begin
    s       = ar[0] ^ br[0] ^ c;
    cy      = (ar[0] & br[0]) | (ar[0] & c) | (br[0] & c);
    last    = (count == CW'(WIDTH - 1));
    // Shift the new sum bit in at the MSB; written without a slice so it
    // stays legal when WIDTH is 1.
    sr_next = (sr >> 1) | (WIDTH'(s) << (WIDTH - 1));
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (last)  state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Operand capture, bit-serial datapath and result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      ar       <= '0;
      br       <= '0;
      sr       <= '0;
      c        <= 1'b0;
      count    <= '0;
      sum      <= '0;
      carryOut <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            ar    <= a;
            br    <= b;
            c     <= carryIn;
            count <= '0;
          end
        end
        RUN: begin
          c     <= cy;
          sr    <= sr_next;
          ar    <= ar >> 1;
          br    <= br >> 1;
          count <= count + CW'(1);
          if (last) begin
            sum      <= sr_next;
            carryOut <= cy;
          end
        end
        default: ;
      endcase
    end
  end

  // Status flags decoded straight from the registered state
  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed table, busy/held-start/reset
// sequences, randomized operations against a + b + cin, and a WIDTH=1 instance.
module tb_serial_adder;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] a, b;
  logic         carryIn;
  logic [W-1:0] sum;
  logic         carryOut, busy, done;

  logic         start1;
  logic [0:0]   a1, b1;
  logic         cin1;
  logic [0:0]   sum1;
  logic         co1, busy1, done1;

  int n_cmp = 0;
  int n_bad = 0;

  logic [W-1:0] prev_sum = '0;
  logic         prev_co  = 1'b0;

  serial_adder #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .carryIn(carryIn),
    .sum(sum), .carryOut(carryOut), .busy(busy), .done(done)
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .a(a1), .b(b1), .carryIn(cin1),
    .sum(sum1), .carryOut(co1), .busy(busy1), .done(done1)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] s;
    logic         co;
  } vec_t;

  vec_t tbl[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with it idle.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                        input logic tcin, input logic [W-1:0] es, input logic eco,
                        input string name);
    int lat;
    lat     = 0;
    start   = 1'b1;
    a       = ta;
    b       = tb;
    carryIn = tcin;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (done) begin
        lat = i;
        break;
      end
      check({name, " busy"}, busy, 1);
      check({name, " hold"}, {prev_co, prev_sum}, {carryOut, sum});
      start   = 1'b0;
      a       = W'($urandom);
      b       = W'($urandom);
      carryIn = 1'($urandom);
    end
    start = 1'b0;
    check({name, " latency"}, lat, W + 1);
    check({name, " busy@done"}, busy, 1);
    check({name, " sum"}, sum, es);
    check({name, " carry"}, carryOut, eco);
    @(negedge clk);
    check({name, " done pulse"}, done, 0);
    check({name, " idle"}, busy, 0);
    prev_sum = es;
    prev_co  = eco;
  endtask

  // Reference: plain (W+1)-bit addition.
  function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic ci);
    return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W:0] r;
    logic [W-1:0] ra, rb;
    logic rc;
    int ndone, t1, t2, k;

    tbl[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0};
    tbl[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    tbl[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    tbl[3] = '{8'h05, 8'hF8, 1'b1, 8'hFE, 1'b0};
    tbl[4] = '{8'h07, 8'hFA, 1'b1, 8'h02, 1'b1};
    tbl[5] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    tbl[6] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1};

    reset = 1'b1; start = 1'b0; a = '0; b = '0; carryIn = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset sum", sum, 0);
    check("reset carry", carryOut, 0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++)
      run_op(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].s, tbl[i].co, $sformatf("vec%0d", i));

    // Start requests during RUN and DONE must be ignored
    start = 1'b1; a = 8'h12; b = 8'h34; carryIn = 1'b0;
    ndone = 0;
    k = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (done) begin
        k = i;
        break;
      end
      start = (i == 3);
      a = (i == 3) ? 8'hAA : 8'h12;
    end
    check("busyign latency", k, W + 1);
    check("busyign sum", sum, 8'h46);
    check("busyign carry", carryOut, 0);
    start = 1'b1; a = 8'hAA;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("busyign extra done", ndone, 0);
    check("busyign idle", busy, 0);
    prev_sum = 8'h46; prev_co = 1'b0;

    // Held start: back-to-back operations W+2 cycles apart
    start = 1'b1; a = 8'h01; b = 8'h01; carryIn = 1'b0;
    ndone = 0; t1 = 0; t2 = 0;
    for (int i = 1; i <= 25; i++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        if (ndone == 1) t1 = i; else if (ndone == 2) t2 = i;
        check("held sum", sum, 8'h02);
        check("held carry", carryOut, 0);
      end
    end
    start = 1'b0;
    check("held count", ndone, 2);
    check("held first", t1, W + 1);
    check("held spacing", t2 - t1, W + 2);
    k = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (!busy) begin
        k = 1;
        break;
      end
    end
    check("held drain", k, 1);
    prev_sum = 8'h02; prev_co = 1'b0;

    // Reset in the 4th RUN cycle aborts the operation
    start = 1'b1; a = 8'h33; b = 8'h44; carryIn = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    check("abort busy before", busy, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort busy", busy, 0);
    check("abort done", done, 0);
    check("abort sum", sum, 0);
    check("abort carry", carryOut, 0);
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    check("abort quiet", ndone, 0);
    prev_sum = '0; prev_co = 1'b0;
    run_op(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, "post-abort");

    // Randomized operations against the reference sum
    for (int n = 0; n < 40; n++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      if (n % 8 == 0) rb = ~ra;
      r = ref_add(ra, rb, rc);
      run_op(ra, rb, rc, r[W-1:0], r[W], $sformatf("rnd%0d", n));
    end

    // WIDTH=1: done two cycles after the start edge
    for (int v = 0; v < 8; v++) begin
      logic [2:0] vb;
      logic [1:0] e1;
      vb = 3'(v);
      e1 = {1'b0, vb[2]} + {1'b0, vb[1]} + {1'b0, vb[0]};
      start1 = 1'b1; a1 = vb[2]; b1 = vb[1]; cin1 = vb[0];
      @(negedge clk);
      start1 = 1'b0; a1 = ~vb[2]; b1 = ~vb[1]; cin1 = ~vb[0];
      check("w1 busy", busy1, 1);
      check("w1 early done", done1, 0);
      @(negedge clk);
      check("w1 done", done1, 1);
      check("w1 result", {co1, sum1}, e1);
      @(negedge clk);
      check("w1 idle", {busy1, done1}, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
